// File: rtl/conv_encoder_r12.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready handshakes on both sides.
// Define CONV_ENC_TAIL_EN for zero-tail termination (K-1 flush symbols close every frame).
module conv_encoder_r12 #(
    parameter int           K  = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_sym,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

`ifdef CONV_ENC_TAIL_EN
    typedef enum logic [1:0] {IDLE, ENC, FLUSH} state_t;
    localparam int CW = $clog2(K);
    logic [CW-1:0] cnt, cnt_next;
`else
    typedef enum logic {IDLE, ENC} state_t;
`endif

    state_t       state, state_next;
    logic [K-2:0] sr, sr_next;
    logic [K-1:0] w;
    logic         b, can_load, accept, step;
    logic [1:0]   sym_next;
    logic         last_next, valid_next;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        sr_next    = sr;
        sym_next   = out_sym;
        last_next  = out_last;
        valid_next = out_valid;
`ifdef CONV_ENC_TAIL_EN
        cnt_next   = cnt;
`endif
        can_load = !out_valid || out_ready;
        in_ready = rst_n && (state == IDLE || state == ENC) && can_load;
        accept   = in_valid && in_ready;
        step     = accept;
`ifdef CONV_ENC_TAIL_EN
        if (state == FLUSH && can_load) step = 1'b1;
`endif
        // Gating with accept keeps a don't-care in_bit out of the shift register.
        b = accept & in_bit;
        w = {b, sr};

        if (can_load) begin
            valid_next = step;
            last_next  = 1'b0;
            if (step) begin
                sym_next = {^(w & G0), ^(w & G1)};
                sr_next  = w[K-1:1];
            end
        end

        case (state)
            IDLE, ENC: begin
                if (accept) begin
                    if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                        state_next = FLUSH;
                        cnt_next   = CW'(K - 1);
`else
                        state_next = IDLE;
                        last_next  = 1'b1;
                        sr_next    = '0;
`endif
                    end else begin
                        state_next = ENC;
                    end
                end
            end
`ifdef CONV_ENC_TAIL_EN
            FLUSH: begin
                if (can_load) begin
                    if (cnt == CW'(1)) begin
                        state_next = IDLE;
                        last_next  = 1'b1;
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            out_sym   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            sr        <= sr_next;
            out_sym   <= sym_next;
            out_valid <= valid_next;
            out_last  <= last_next;
        end
    end

`ifdef CONV_ENC_TAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end
`endif

endmodule

// File: tb/tb_conv_encoder_r12.sv
// Scoreboard bench for conv_encoder_r12 (K=3, G0=7, G1=5); expectations are packed {last, g0, g1}.
// Works in both builds: CONV_ENC_TAIL_EN selects the zero-tail expectations.
module tb_conv_encoder_r12;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, busy;
    logic [1:0] out_sym;

    int         n_checks = 0, n_pass = 0;
    logic [2:0] exp_q[$];
    int         ready_mode = 2;
    int         ready_cyc = 0;
    logic       stall_prev = 1'b0;
    logic [2:0] held = '0;

    conv_encoder_r12 dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // out_ready: 0 = always high, 1 = repeating 1,0,0,1 pattern, 2 = random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_cyc % 4 == 0) || (ready_cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        ready_cyc++;
    end

    // Monitor: inputs change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {out_valid, out_last, out_sym}, {1'b1, held});
            if (out_valid && !out_ready)
                check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                check("sym_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("sym", {out_last, out_sym}, exp_q.pop_front());
            end
            stall_prev <= out_valid && !out_ready;
            held       <= {out_last, out_sym};
        end
    end

    task automatic push(input logic [2:0] v);
        exp_q.push_back(v);
    endtask

    task automatic send_bit(input logic b, input logic last);
        logic acc;
        int   g;
        acc = 1'b0;
        g = 0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        while (!acc && g < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        check("in_accept", acc, 1);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_1011();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic push_1011();
`ifdef CONV_ENC_TAIL_EN
        push(3'b011); push(3'b010); push(3'b000); push(3'b001); push(3'b001); push(3'b111);
`else
        push(3'b011); push(3'b010); push(3'b000); push(3'b101);
`endif
    endtask

    task automatic push_single_one();
`ifdef CONV_ENC_TAIL_EN
        push(3'b011); push(3'b010); push(3'b111);
`else
        push(3'b111);
`endif
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random stimulus
        for (int i = 0; i < 3; i++) begin
            in_bit   = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sym", out_sym, 0);
            check("rst_busy", busy, 0);
            check("rst_in_ready", in_ready, 0);
        end
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        in_last    = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_last", out_last, 0);
        @(posedge clk);
        #1;

        // Frame 1011, downstream always ready
        push_1011();
        send_1011();
        drain();

        // Same frame under back-pressure
        ready_cyc  = 0;
        ready_mode = 1;
        push_1011();
        send_1011();
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Single-bit frame
        push_single_one();
        send_bit(1'b1, 1'b1);
`ifdef CONV_ENC_TAIL_EN
        @(negedge clk);
        check("flush_busy0", busy, 1);
        check("flush_in_ready0", in_ready, 0);
        @(negedge clk);
        check("flush_busy1", busy, 1);
        check("flush_in_ready1", in_ready, 0);
        @(negedge clk);
        check("flush_busy_done", busy, 0);
`else
        @(negedge clk);
        check("trunc_busy_done", busy, 0);
`endif
        drain();

        // Back-to-back frames; the second one's first bit is offered during the first one's flush
`ifdef CONV_ENC_TAIL_EN
        push(3'b011); push(3'b001); push(3'b001); push(3'b111);
        push(3'b000); push(3'b011); push(3'b010); push(3'b111);
`else
        push(3'b011); push(3'b101);
        push(3'b000); push(3'b111);
`endif
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        drain();

        // Reset pulse right after the last data bit of 1011 is accepted
        push_1011();
        send_1011();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_sym", out_sym, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_single_one();
        send_bit(1'b1, 1'b1);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
